// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer: drives a read-only async SRAM with a fixed wait per word
// and hands fetched {pc, word} pairs to the execute stage through a small FIFO.
module ins_fetch_ctrl #(
    parameter int unsigned       ADDR_W      = 18,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       WAIT_CYCLES = 3,
    parameter int unsigned       FIFO_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [DATA_W-1:0] SRAM_D,
    output logic              SRAM_WE,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              ins_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt
);

    localparam int unsigned WCNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [WCNT_W-1:0] wcnt;

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;

    logic capture;
    logic pop;
    logic space;

    // Read-only access with both bytes always enabled.
    assign SRAM_WE = 1'b1;
    assign SRAM_CE = 1'b0;
    assign SRAM_OE = 1'b0;
    assign SRAM_LB = 1'b0;
    assign SRAM_UB = 1'b0;

    assign ins_valid = (count != '0);
    assign ins_data  = ins_valid ? data_mem[rd_ptr] : '0;
    assign ins_pc    = ins_valid ? pc_mem[rd_ptr]   : '0;

    assign capture = (state == StWait) && (wcnt == WCNT_LAST);
    assign pop     = ins_valid && ins_ready;
    assign pc_inc  = fetch_pc + PC_ONE;

    // Occupancy after this edge; an issue is allowed only if it leaves a free slot for its word.
    always_comb begin
        count_after = count;
        if (capture && !pop) begin
            count_after = count + CNT_ONE;
        end else if (!capture && pop) begin
            count_after = count - CNT_ONE;
        end
    end

    assign space = (count_after < CNT_FULL);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Fetch FSM: issue an address, hold it for WAIT_CYCLES edges, then capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= StIdle;
            fetch_pc <= START_ADDR;
            SRAM_A   <= START_ADDR;
            wcnt     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_addr;
            if (!halt) begin
                SRAM_A <= redirect_addr;
                wcnt   <= WCNT_ONE;
                state  <= StWait;
            end else begin
                wcnt  <= '0;
                state <= StIdle;
            end
        end else begin
            case (state)
                StIdle: begin
                    if (!halt && space) begin
                        SRAM_A <= fetch_pc;
                        wcnt   <= WCNT_ONE;
                        state  <= StWait;
                    end
                end
                StWait: begin
                    if (!capture) begin
                        wcnt <= wcnt + WCNT_ONE;
                    end else begin
                        fetch_pc <= pc_inc;
                        if (!halt && space) begin
                            SRAM_A <= pc_inc;
                            wcnt   <= WCNT_ONE;
                        end else begin
                            wcnt  <= '0;
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Prefetch buffer; a redirect flushes it, dropping any word captured on the same edge.
    always_ff @(posedge CLK) begin
        if (RST || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                data_mem[wr_ptr] <= SRAM_D;
                pc_mem[wr_ptr]   <= fetch_pc;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count_after;
        end
    end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Bench for ins_fetch_ctrl: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_ins_fetch_ctrl;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WAITC  = 3;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic              sram_we, sram_ce, sram_oe, sram_lb, sram_ub;
    logic              ins_valid;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] seq_data [4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};

    always #10 clk = ~clk;

    // SRAM contents: word at address A is A[15:0] ^ 16'hA5A5.
    assign sram_d = sram_a[15:0] ^ 16'hA5A5;

    ins_fetch_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAITC),
        .FIFO_DEPTH  (DEPTH),
        .START_ADDR  ('0)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .SRAM_A        (sram_a),
        .SRAM_D        (sram_d),
        .SRAM_WE       (sram_we),
        .SRAM_CE       (sram_ce),
        .SRAM_OE       (sram_oe),
        .SRAM_LB       (sram_lb),
        .SRAM_UB       (sram_ub),
        .ins_valid     (ins_valid),
        .ins_data      (ins_data),
        .ins_pc        (ins_pc),
        .ins_ready     (ins_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer as a queue of pcs, one outstanding fetch with edges left.
    logic [ADDR_W-1:0] m_q[$];
    logic [ADDR_W-1:0] m_fpc;
    logic [ADDR_W-1:0] m_a;
    bit                m_busy;
    int                m_left;
    bit                m_init = 1'b0;

    task automatic model_step();
        bit do_pop;
        bit done;
        if (rst) begin
            m_q.delete();
            m_fpc  = '0;
            m_a    = '0;
            m_busy = 1'b0;
            m_left = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            do_pop = (m_q.size() != 0) && ins_ready;
            if (redirect) begin
                m_q.delete();
                m_fpc  = redirect_addr;
                m_busy = 1'b0;
                if (!halt) begin
                    m_a    = redirect_addr;
                    m_busy = 1'b1;
                    m_left = WAITC;
                end
            end else begin
                done = m_busy && (m_left == 1);
                if (m_busy && !done) m_left--;
                if (do_pop) void'(m_q.pop_front());
                if (done) begin
                    m_q.push_back(m_fpc);
                    m_fpc  = m_fpc + 1'b1;
                    m_busy = 1'b0;
                end
                if (!m_busy && !halt && m_q.size() < DEPTH) begin
                    m_a    = m_fpc;
                    m_busy = 1'b1;
                    m_left = WAITC;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            check("cmp_valid", 32'(ins_valid), 32'(m_q.size() != 0));
            check("cmp_sram_a", 32'(sram_a), 32'(m_a));
            check("cmp_strobes", 32'({sram_we, sram_ce, sram_oe, sram_lb, sram_ub}),
                  32'(5'b10000));
            if (m_q.size() != 0) begin
                check("cmp_pc", 32'(ins_pc), 32'(m_q[0]));
                check("cmp_data", 32'(ins_data), 32'(m_q[0][15:0] ^ 16'hA5A5));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rst       = 1'b1;
        redirect  = 1'b0;
        halt      = 1'b0;
        ins_ready = rdy;
        tick();
        tick();
        check("reset_valid", 32'(ins_valid), 32'd0);
        check("reset_pc", 32'(ins_pc), 32'd0);
        check("reset_data", 32'(ins_data), 32'd0);
        check("reset_sram_a", 32'(sram_a), 32'd0);
        rst = 1'b0;
    endtask

    // Fresh sequence with ready=1: pcs 0..3 appear after edges 4, 7, 10, 13.
    task automatic run_seq1(input string tag);
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k < 4 || k == 5) check({tag, "_idle_valid"}, 32'(ins_valid), 32'd0);
            if (k >= 4 && (k - 4) % 3 == 0) begin
                check({tag, "_valid"}, 32'(ins_valid), 32'd1);
                check({tag, "_pc"}, 32'(ins_pc), 32'((k - 4) / 3));
                check({tag, "_data"}, 32'(ins_data), 32'(seq_data[(k - 4) / 3]));
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        ins_ready     = 1'b1;
        redirect      = 1'b0;
        redirect_addr = '0;
        halt          = 1'b0;

        // 1: basic streaming
        do_reset(1'b1);
        run_seq1("t1");

        // 2: back-pressure fills the buffer, then drains
        do_reset(1'b0);
        for (int k = 1; k <= 10; k++) tick();
        check("t2_full_valid", 32'(ins_valid), 32'd1);
        check("t2_full_pc", 32'(ins_pc), 32'd0);
        check("t2_full_data", 32'(ins_data), 32'hA5A5);
        check("t2_full_sram_a", 32'(sram_a), 32'd1);
        ins_ready = 1'b1;
        tick();
        check("t2_drain_pc", 32'(ins_pc), 32'd1);
        check("t2_resume_sram_a", 32'(sram_a), 32'd2);
        tick();
        check("t2_empty", 32'(ins_valid), 32'd0);
        tick();
        tick();
        check("t2_pc2", 32'(ins_pc), 32'd2);
        check("t2_data2", 32'(ins_data), 32'hA5A7);

        // 3: redirect with a buffered word and a fetch in flight
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) tick();
        check("t3_pre_valid", 32'(ins_valid), 32'd1);
        check("t3_pre_sram_a", 32'(sram_a), 32'd1);
        redirect      = 1'b1;
        redirect_addr = 18'h00100;
        tick();
        redirect  = 1'b0;
        ins_ready = 1'b1;
        check("t3_flush_valid", 32'(ins_valid), 32'd0);
        check("t3_new_sram_a", 32'(sram_a), 32'h00100);
        tick();
        check("t3_no_stale1", 32'(ins_valid), 32'd0);
        tick();
        check("t3_no_stale2", 32'(ins_valid), 32'd0);
        tick();
        check("t3_pc", 32'(ins_pc), 32'h00100);
        check("t3_data", 32'(ins_data), 32'hA4A5);

        // 4: redirect to the top address, pc wraps to 0
        redirect      = 1'b1;
        redirect_addr = 18'h3FFFF;
        tick();
        redirect = 1'b0;
        check("t4_flush_valid", 32'(ins_valid), 32'd0);
        check("t4_sram_a", 32'(sram_a), 32'h3FFFF);
        tick();
        tick();
        tick();
        check("t4_pc_top", 32'(ins_pc), 32'h3FFFF);
        check("t4_data_top", 32'(ins_data), 32'h5A5A);
        tick();
        tick();
        tick();
        check("t4_pc_wrap", 32'(ins_pc), 32'd0);
        check("t4_data_wrap", 32'(ins_data), 32'hA5A5);

        // 5: halt raised mid-WAIT
        do_reset(1'b1);
        tick();
        halt = 1'b1;
        tick();
        tick();
        tick();
        check("t5_inflight_valid", 32'(ins_valid), 32'd1);
        check("t5_inflight_pc", 32'(ins_pc), 32'd0);
        for (int k = 5; k <= 9; k++) begin
            tick();
            check("t5_halt_sram_a", 32'(sram_a), 32'd0);
        end
        halt = 1'b0;
        tick();
        check("t5_resume_sram_a", 32'(sram_a), 32'd1);
        tick();
        tick();
        tick();
        check("t5_resume_pc", 32'(ins_pc), 32'd1);

        // 6: reset mid-WAIT with one buffered word
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) tick();
        check("t6_pre_valid", 32'(ins_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", 32'(ins_valid), 32'd0);
        check("t6_rst_sram_a", 32'(sram_a), 32'd0);
        rst       = 1'b0;
        ins_ready = 1'b1;
        run_seq1("t6");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
